// File: rtl/wallace_csa_reducer.sv
// Sequential carry-save multiplier front end: folds ROWS_PER_CYCLE partial-product
// rows per clock into a redundant (sum, carry) pair consumed directly by adder_64.
//   state  | meaning
//   IDLE   | ready for an operand pair
//   REDUCE | folding one group of rows per cycle into S/C
//   HOLD   | result presented, waiting for out_ready
module wallace_csa_reducer #(
  parameter int WIDTH          = 32,
  parameter int ROWS_PER_CYCLE = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   sum_vec,
  output logic [2*WIDTH-1:0]   carry_vec
);

  localparam int W2    = 2 * WIDTH;
  localparam int R     = (ROWS_PER_CYCLE < 1) ? 1 : ROWS_PER_CYCLE;
  localparam int STEPS = WIDTH / R;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int NOPS  = R + 2;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  generate
    if ((ROWS_PER_CYCLE < 1) || ((WIDTH % R) != 0)) begin : g_bad_params
      $error("wallace_csa_reducer: ROWS_PER_CYCLE must be >= 1 and divide WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, REDUCE, HOLD} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_r, b_r;
  logic [CW-1:0]    cnt;
  logic [W2-1:0]    s_r, c_r;
  logic [W2-1:0]    s_nxt, c_nxt;

  logic [W2-1:0]    ops [NOPS];
  logic [W2-1:0]    nxt [NOPS];
  int               n, groups, rem, row;

  // Wallace reduction: every level turns each triple into a sum/carry pair and
  // passes leftovers through, until only two vectors remain.
  always_comb begin
    row    = 0;
    n      = NOPS;
    groups = 0;
    rem    = 0;
    for (int i = 0; i < NOPS; i++) begin
      ops[i] = '0;
      nxt[i] = '0;
    end
    ops[0] = s_r;
    ops[1] = c_r;
    for (int j = 0; j < R; j++) begin
      row        = int'(cnt) * R + j;
      ops[j + 2] = b_r[row] ? (W2'(a_r) << row) : '0;
    end
    for (int lvl = 0; lvl < NOPS; lvl++) begin
      if (n > 2) begin
        groups = n / 3;
        rem    = n % 3;
        for (int i = 0; i < NOPS; i++) nxt[i] = '0;
        for (int g = 0; g < NOPS / 3; g++) begin
          if (g < groups) begin
            nxt[2*g]     = ops[3*g] ^ ops[3*g+1] ^ ops[3*g+2];
            nxt[2*g + 1] = ((ops[3*g] & ops[3*g+1]) | (ops[3*g] & ops[3*g+2]) |
                            (ops[3*g+1] & ops[3*g+2])) << 1;
          end
        end
        for (int t = 0; t < 2; t++) begin
          if (t < rem) nxt[2*groups + t] = ops[3*groups + t];
        end
        for (int i = 0; i < NOPS; i++) ops[i] = nxt[i];
        n = 2 * groups + rem;
      end
    end
    s_nxt = ops[0];
    c_nxt = ops[1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      a_r       <= '0;
      b_r       <= '0;
      cnt       <= '0;
      s_r       <= '0;
      c_r       <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_r      <= a;
            b_r      <= b;
            s_r      <= '0;
            c_r      <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= REDUCE;
          end
        end
        REDUCE: begin
          s_r <= s_nxt;
          c_r <= c_nxt;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            out_valid <= 1'b1;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign sum_vec   = s_r;
  assign carry_vec = c_r;

endmodule
